// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Pops words from a first-word-fall-through FIFO and presents them as a
// valid/ready stream grouped into bursts of BURST_LEN beats. Two words of
// local storage (an output register and a skid register) keep the FIFO pop
// strobe independent of m_ready while still sustaining one beat per cycle.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   enable       : allows new pops; held data still drains when low
//   flush        : synchronous discard of held data and burst position
//   fifo_empty   : FIFO empty flag
//   fifo_data    : FIFO head word (valid whenever fifo_empty is low)
//   fifo_r_ready : pop strobe, one word consumed per high cycle
//   m_valid      : output beat valid
//   m_ready      : downstream accepts the beat
//   m_data       : output beat data
//   m_last       : final beat of each burst
//   occupancy    : words held internally (0, 1 or 2)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int WIDTH     = 64,
    parameter int BURST_LEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_r_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [1:0]       occupancy
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] skid_q;
    logic [CW-1:0]    beat_cnt;
    logic             pop;
    logic             acc;

    // Burst position wraps after the last beat; with BURST_LEN=1 it stays 0.
    function automatic logic [CW-1:0] next_beat(input logic [CW-1:0] cnt);
        if (cnt == LAST_BEAT) begin
            return '0;
        end
        return cnt + CW'(1);
    endfunction

    // The pop decision never looks at m_ready: the skid register absorbs the
    // word popped in the cycle the downstream stalls. rst_n is folded in so
    // no pop can be signalled while reset is held.
    assign fifo_r_ready = rst_n & enable & ~fifo_empty & ~flush & (state != TWO);
    assign pop          = fifo_r_ready;
    assign acc          = m_valid & m_ready;

    // All stream outputs are decoded from registered state only.
    assign m_valid   = (state != EMPTY);
    assign m_data    = out_q;
    assign m_last    = m_valid & (beat_cnt == LAST_BEAT);
    assign occupancy = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_q    <= '0;
            skid_q   <= '0;
            beat_cnt <= '0;
        end else if (flush) begin
            // Flush wins over pop and accept; a beat taken this cycle is not
            // counted so the next burst starts cleanly at beat 0.
            state    <= EMPTY;
            beat_cnt <= '0;
        end else begin
            if (acc) begin
                beat_cnt <= next_beat(beat_cnt);
            end
            case (state)
                EMPTY: begin
                    if (pop) begin
                        out_q <= fifo_data;
                        state <= ONE;
                    end
                end
                ONE: begin
                    case ({pop, acc})
                        2'b11: out_q <= fifo_data;
                        2'b10: begin
                            skid_q <= fifo_data;
                            state  <= TWO;
                        end
                        2'b01: state <= EMPTY;
                        default: begin
                        end
                    endcase
                end
                TWO: begin
                    if (acc) begin
                        out_q <= skid_q;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Self-checking bench for fifo_rd_stream (WIDTH=64, BURST_LEN=16). A queue
// models the FWFT FIFO; a second queue holds popped-but-not-accepted words.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int W  = 64;
    localparam int BL = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         flush;
    logic         fifo_empty;
    logic [W-1:0] fifo_data;
    logic         fifo_r_ready;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic [1:0]   occupancy;

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .WIDTH     (W),
        .BURST_LEN (BL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .flush        (flush),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_r_ready (fifo_r_ready),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .occupancy    (occupancy)
    );

    int           n_checks  = 0;
    int           n_errors  = 0;
    int           bcnt      = 0;
    int           acc_total = 0;
    bit           hold_empty = 1'b0;
    logic [W-1:0] fq[$];
    logic [W-1:0] sb[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = hold_empty || (fq.size() == 0);
        fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // One clock: sample just before the edge, update models, advance.
    task automatic cycle();
        logic         p;
        logic         a;
        logic [W-1:0] d;
        #1;
        p = fifo_r_ready;
        a = m_valid & m_ready;
        d = fifo_data;
        check("occ_vs_model", W'(occupancy), W'(sb.size()));
        if (fifo_empty) check("rdy_when_empty", W'(fifo_r_ready), 0);
        if (flush) begin
            check("rdy_in_flush", W'(p), 0);
            sb.delete();
            bcnt = 0;
        end else begin
            if (a) begin
                acc_total++;
                check("beat_has_word", W'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    check("beat_data", m_data, sb.pop_front());
                    check("beat_last", W'(m_last), W'(bcnt == BL - 1));
                    bcnt = (bcnt + 1) % BL;
                end
            end
            if (p) sb.push_back(d);
        end
        @(posedge clk);
        #1;
        if (p && fq.size() != 0) fq.delete(0);
        drive_fifo();
        #1;
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        sb.delete();
        bcnt = 0;
        repeat (2) cycle();
        check("rst_m_valid", W'(m_valid), 0);
        check("rst_m_last", W'(m_last), 0);
        check("rst_occ", W'(occupancy), 0);
        check("rst_r_ready", W'(fifo_r_ready), 0);
        check("rst_m_data", m_data, 0);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) fq.push_back(W'(i));
        drive_fifo();
    endtask

    // 40 preloaded words at full rate: 1-cycle latency, m_last on 15 and 31.
    task automatic stream40();
        enable  = 1'b1;
        m_ready = 1'b1;
        #1;
        check("s40_first_invalid", W'(m_valid), 0);
        check("s40_first_pop", W'(fifo_r_ready), 1);
        cycle();
        for (int k = 0; k < 40; k++) begin
            check("s40_valid", W'(m_valid), 1);
            check("s40_data", m_data, W'(k));
            check("s40_last", W'(m_last), W'(k == 15 || k == 31));
            cycle();
        end
        check("s40_drained", W'(m_valid), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b1;
        load(5);

        // Reset with a non-empty FIFO: no pop may be signalled.
        enter_reset();
        fq.delete();
        drive_fifo();
        rst_n = 1'b1;

        // Empty FIFO for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("idle_valid", W'(m_valid), 0);
            check("idle_r_ready", W'(fifo_r_ready), 0);
            check("idle_occ", W'(occupancy), 0);
        end

        // Full-rate stream of 0..39.
        load(40);
        stream40();

        // Backpressure for 5 cycles after the first beat.
        enter_reset();
        fq.delete();
        rst_n = 1'b1;
        load(10);
        m_ready = 1'b1;
        cycle();
        check("bp_first", m_data, 0);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_hold_valid", W'(m_valid), 1);
            check("bp_hold_data", m_data, 0);
            check("bp_hold_last", W'(m_last), 0);
        end
        check("bp_occ2", W'(occupancy), 2);
        check("bp_r_ready_low", W'(fifo_r_ready), 0);
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", W'(m_valid), 1);
            check("bp_data", m_data, W'(k));
            cycle();
        end
        check("bp_drained", W'(m_valid), 0);

        // Flush in TWO at beat 7 of a burst.
        enter_reset();
        fq.delete();
        rst_n = 1'b1;
        load(40);
        m_ready = 1'b1;
        cycle();
        for (int k = 0; k < 7; k++) cycle();
        check("fl_beat7", m_data, 7);
        m_ready = 1'b0;
        cycle();
        check("fl_occ2", W'(occupancy), 2);
        flush   = 1'b1;
        m_ready = 1'b1;
        cycle();
        flush = 1'b0;
        check("fl_occ0", W'(occupancy), 0);
        check("fl_invalid", W'(m_valid), 0);
        cycle();
        for (int k = 0; k < 16; k++) begin
            check("fl_data", m_data, W'(9 + k));
            check("fl_last", W'(m_last), W'(k == 15));
            cycle();
        end

        // Asynchronous reset while in TWO.
        enter_reset();
        fq.delete();
        rst_n = 1'b1;
        load(40);
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        cycle();
        check("ar_occ2", W'(occupancy), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", W'(m_valid), 0);
        check("ar_occ", W'(occupancy), 0);
        check("ar_r_ready", W'(fifo_r_ready), 0);
        check("ar_last", W'(m_last), 0);
        check("ar_data", m_data, 0);
        sb.delete();
        bcnt = 0;
        fq.delete();
        cycle();
        cycle();
        rst_n = 1'b1;
        load(40);
        stream40();

        // Randomised enable / m_ready / fifo_empty against the scoreboard.
        enter_reset();
        fq.delete();
        drive_fifo();
        rst_n = 1'b1;
        acc_total = 0;
        for (int i = 0; i < 5000; i++) begin
            enable     = ($urandom_range(0, 9) < 8);
            m_ready    = ($urandom_range(0, 9) < 7);
            hold_empty = ($urandom_range(0, 9) < 3);
            if (fq.size() < 4) fq.push_back({$urandom, $urandom});
            drive_fifo();
            cycle();
        end
        check("rand_beats_seen", W'(acc_total > 1000), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
